// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, types and the blitter state encoding.
`timescale 1ns/1ps
package fb_pkg;
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;

  // Duplicate black palette entry reserved as the transparent key.
  localparam logic [7:0] TRANSP_IDX = 8'd16;

  typedef logic [18:0] fb_addr_t;
  typedef logic [7:0]  color_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Request, sprite-ROM read and frameRAM write signals of the sprite blitter.
`timescale 1ns/1ps
interface sprite_blitter_if;
  import fb_pkg::*;

  // Handshake: start is a level sampled on any edge where the blitter is
  // IDLE; busy covers RUN and FLUSH, and done pulses one cycle afterwards.
  logic        start;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [15:0] spr_base;
  logic [15:0] rom_addr;
  color_idx_t  rom_data;
  logic        fb_we;
  fb_addr_t    fb_addr;
  color_idx_t  fb_data;
  logic        busy;
  logic        done;
  blit_state_t state;

  modport master (
    output start, spr_x, spr_y, spr_base, rom_data,
    input  rom_addr, fb_we, fb_addr, fb_data, busy, done, state
  );

  modport slave (
    input  start, spr_x, spr_y, spr_base, rom_data,
    output rom_addr, fb_we, fb_addr, fb_data, busy, done, state
  );
endinterface

// File: rtl/blit_addr_gen.sv
// Sprite pixel walker: col/row counters, sprite-ROM address and the
// registered destination coordinates with on-screen flag.
`timescale 1ns/1ps
module blit_addr_gen
  import fb_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [15:0] base,
  output logic [15:0] rom_addr,
  output logic        last,
  output logic [10:0] dx,
  output logic [10:0] dy,
  output logic        on
);
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic [15:0]      base_q;
  logic [10:0]      dx_next;
  logic [10:0]      dy_next;
  logic             col_last;

  assign col_last = (col == COL_W'(SPR_W - 1));
  assign last     = col_last && (row == ROW_W'(SPR_H - 1));

  // Address wraps modulo 2^16 and is parked at zero outside RUN.
  assign rom_addr = advance ? (base_q + 16'(row) * 16'(SPR_W) + 16'(col)) : 16'd0;

  assign dx_next = 11'(x_q) + 11'(col);
  assign dy_next = 11'(y_q) + 11'(row);

  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
      dx     <= '0;
      dy     <= '0;
      on     <= 1'b0;
    end else if (load) begin
      col    <= '0;
      row    <= '0;
      x_q    <= x;
      y_q    <= y;
      base_q <= base;
    end else if (advance) begin
      dx <= dx_next;
      dy <= dy_next;
      on <= (dx_next < 11'(FB_W)) && (dy_next < 11'(FB_H));
      if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite from ROM into the frameRAM with transparency and
// right/bottom clipping, one pixel per cycle.
`timescale 1ns/1ps
module sprite_blitter
  import fb_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input logic             Clk,
  input logic             Reset,
  sprite_blitter_if.slave bus
);
  blit_state_t state;
  logic        busy_q;
  logic        done_q;
  logic        pv;
  logic        load;
  logic        advance;
  logic        last;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        on;

  assign load    = (state == IDLE) && bus.start;
  assign advance = (state == RUN);

  blit_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_addr_gen (
    .clk      (Clk),
    .rst      (Reset),
    .load     (load),
    .advance  (advance),
    .x        (bus.spr_x),
    .y        (bus.spr_y),
    .base     (bus.spr_base),
    .rom_addr (bus.rom_addr),
    .last     (last),
    .dx       (dx),
    .dy       (dy),
    .on       (on)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pv     <= 1'b0;
    end else begin
      // Stage-1 valid follows RUN; FLUSH exists only to drain this slot.
      pv <= advance;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (last) state <= FLUSH;
        end
        FLUSH: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: ROM data arrives one cycle after its address, aligned with pv.
  assign bus.fb_we   = pv && on && (bus.rom_data != TRANSP_IDX);
  assign bus.fb_addr = fb_addr_t'(19'(dy) * 19'(FB_W) + 19'(dx));
  assign bus.fb_data = pv ? bus.rom_data : '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state   = state;
endmodule
